booth_ctrl: RTL and testbench

Sequencing FSM for the 8-bit radix-2 Booth multiplier datapath. Accepts a start request, clears and loads the datapath, then issues one add/subtract decision plus one arithmetic-shift per iteration, driven by the datapath's {Q0, Q-1} bit pair. Ends with a single-cycle `done` pulse. Sits between the ALU top-level op decoder and the `booth` datapath, and owns all of that datapath's control strobes.

---
 rtl/booth_ctrl.sv | 68 ++++++
 tb/tb_booth_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_ctrl.sv
// booth_ctrl: sequencing FSM for the 8-bit radix-2 Booth multiplier datapath.
// Optional abort input enabled by defining BOOTH_CTRL_ABORT_EN.
module booth_ctrl #(
    parameter int ITERS = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    q_pair,
`ifdef BOOTH_CTRL_ABORT_EN
    input  logic          abort,
`endif
    output logic          dp_clear,
    output logic          load,
    output logic          add_en,
    output logic          sub_en,
    output logic          shift_en,
    output logic          count_en,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] iter
);
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, EVAL, ADD, SUB, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic kill;
`ifdef BOOTH_CTRL_ABORT_EN
    assign kill = abort && state != IDLE;
`else
    assign kill = 1'b0;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            iter  <= '0;
        end else begin
            state <= state_nx;
            iter  <= state == CLEAR ? '0 : state == SHIFT ? iter + CW'(1) : iter;
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? CLEAR : IDLE;
            CLEAR:   state_nx = LOAD;
            LOAD:    state_nx = EVAL;
            EVAL:    state_nx = q_pair == 2'b01 ? ADD : q_pair == 2'b10 ? SUB : SHIFT;
            ADD:     state_nx = SHIFT;
            SUB:     state_nx = SHIFT;
            SHIFT:   state_nx = iter == CW'(ITERS - 1) ? DONE : EVAL;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (kill)
            state_nx = IDLE;
    end
    // strobes depend on the state register only
    always_comb begin
        dp_clear = state == CLEAR;
        load     = state == LOAD;
        add_en   = state == ADD;
        sub_en   = state == SUB;
        shift_en = state == SHIFT;
        count_en = state == SHIFT;
        busy     = state != IDLE;
        done     = state == DONE;
    end
endmodule

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl: randomized self-checking bench for booth_ctrl with a behavioural datapath.
// Define BOOTH_CTRL_ABORT_EN to also exercise the abort input.
module tb_booth_ctrl;
    localparam logic [7:0] E_CLR = 8'hC0, E_LD = 8'hA0, E_EV = 8'h80, E_ADD = 8'h90;
    localparam logic [7:0] E_SUB = 8'h88, E_SH = 8'h86, E_DN = 8'h81;

    logic clk = 0, reset = 1, start = 0;
    logic [1:0] q_pair;
    logic dp_clear, load, add_en, sub_en, shift_en, count_en, busy, done;
    logic [3:0] iter;
`ifdef BOOTH_CTRL_ABORT_EN
    logic abort = 0;
`endif
    int checks = 0, errors = 0;

    logic [7:0] mcand = 0, mplier = 0, m_a = 0, dp_a = 0, dp_q = 0;
    logic dp_qm1 = 0, tie_en = 0;
    logic [1:0] tie_val = 0;
    logic [7:0] ov;
    logic [7:0] obs [0:63];
    logic [7:0] expv [0:63];
    logic [15:0] prod [0:63];
    logic [3:0] itv [0:63];
    int explen;

    booth_ctrl #(.ITERS(8), .CW(4)) dut (
        .clk(clk), .reset(reset), .start(start), .q_pair(q_pair),
`ifdef BOOTH_CTRL_ABORT_EN
        .abort(abort),
`endif
        .dp_clear(dp_clear), .load(load), .add_en(add_en), .sub_en(sub_en),
        .shift_en(shift_en), .count_en(count_en), .busy(busy), .done(done), .iter(iter)
    );

    always #5 clk = ~clk;
    assign ov = {busy, dp_clear, load, add_en, sub_en, shift_en, count_en, done};
    assign q_pair = tie_en ? tie_val : {dp_q[0], dp_qm1};

    // behavioural Booth datapath driven by the controller strobes
    always @(posedge clk) begin
        if (dp_clear) begin
            dp_a <= 0; dp_q <= 0; dp_qm1 <= 0;
        end else if (load) begin
            dp_a <= 0; dp_q <= mplier; dp_qm1 <= 0; m_a <= mcand;
        end else if (add_en) dp_a <= dp_a + m_a;
        else if (sub_en) dp_a <= dp_a - m_a;
        else if (shift_en) {dp_a, dp_q, dp_qm1} <= {dp_a[7], dp_a, dp_q};
    end

    // expected per-cycle output vectors from Booth recoding of the multiplier bits
    task automatic build_expect(input logic [7:0] b, input logic te, input logic [1:0] tv);
        int n;
        logic prev;
        logic [1:0] p;
        n = 2; prev = 0;
        expv[1] = E_CLR; expv[2] = E_LD;
        for (int i = 0; i < 8; i++) begin
            p = te ? tv : {b[i], prev};
            prev = b[i];
            n = n + 1; expv[n] = E_EV;
            if (p == 2'b01) begin n = n + 1; expv[n] = E_ADD; end
            else if (p == 2'b10) begin n = n + 1; expv[n] = E_SUB; end
            n = n + 1; expv[n] = E_SH;
        end
        n = n + 1; expv[n] = E_DN;
        expv[n + 1] = 8'h00;
        explen = n;
    endtask

    task automatic capture(input int n, input int r1, input int r2, input logic hold, input logic launched);
        if (!launched) begin
            start = 1; @(posedge clk); #1;
        end
        for (int k = 1; k <= n; k++) begin
            start = hold || k == r1 || k == r2;
            obs[k] = ov; itv[k] = iter; prod[k] = {dp_a, dp_q};
            @(posedge clk); #1;
        end
        start = hold;
    endtask

    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa, sb;
        sa = $signed(a); sb = $signed(b);
        return sa * sb;
    endfunction

    task automatic test_reset;
        #1;
        checks++;
        if (ov !== 8'h00 || iter !== 4'd0) begin
            errors++; $display("FAIL reset_state: got %h iter %0d, want 00 iter 0", ov, iter);
        end
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(posedge clk); #1;
        checks++;
        if (ov !== 8'h00) begin
            errors++; $display("FAIL idle_after_reset: got %h, want 00", ov);
        end
    endtask

    task automatic test_shift_only;
        int dc, ns, na;
        tie_en = 1; tie_val = 2'b00; mcand = 8'h5A; mplier = 8'h00;
        build_expect(8'h00, 1, 2'b00);
        capture(explen + 1, 0, 0, 0, 0);
        dc = 0; ns = 0; na = 0;
        for (int k = 1; k <= explen + 1; k++) begin
            checks++;
            if (obs[k] !== expv[k]) begin
                errors++; $display("FAIL shift_only_c%0d: got %h, want %h", k, obs[k], expv[k]);
            end
            if (obs[k][0] && dc == 0) dc = k;
            ns += int'(obs[k][2]);
            na += int'(obs[k][4]) + int'(obs[k][3]);
        end
        checks++;
        if (dc != 19 || ns != 8 || na != 0) begin
            errors++; $display("FAIL shift_only_counts: done %0d shifts %0d addsub %0d, want 19 8 0", dc, ns, na);
        end
        checks++;
        if (itv[19] !== 4'd8 || itv[3] !== 4'd0) begin
            errors++; $display("FAIL shift_only_iter: got %0d/%0d, want 0/8", itv[3], itv[19]);
        end
        #1;
        checks++;
        if (iter !== 4'd8) begin
            errors++; $display("FAIL iter_hold: got %0d, want 8", iter);
        end
        tie_en = 0;
    endtask

    task automatic test_add_all;
        int dc, na, bad;
        tie_en = 1; tie_val = 2'b01; mcand = 8'h11; mplier = 8'h00;
        build_expect(8'h00, 1, 2'b01);
        capture(explen + 1, 0, 0, 0, 0);
        dc = 0; na = 0; bad = 0;
        for (int k = 1; k <= explen + 1; k++) begin
            checks++;
            if (obs[k] !== expv[k]) begin
                errors++; $display("FAIL add_all_c%0d: got %h, want %h", k, obs[k], expv[k]);
            end
            if (obs[k][0] && dc == 0) dc = k;
            if (obs[k][4]) begin
                na++;
                if (!obs[k + 1][2]) bad++;
            end
        end
        checks++;
        if (dc != 27 || na != 8 || bad != 0) begin
            errors++; $display("FAIL add_all_counts: done %0d adds %0d unfollowed %0d, want 27 8 0", dc, na, bad);
        end
        tie_en = 0;
    endtask

    task automatic test_known;
        mcand = 8'hFB; mplier = 8'h03;
        build_expect(8'h03, 0, 2'b00);
        capture(explen + 1, 0, 0, 0, 0);
        checks++;
        if (explen != 21 || expv[4] !== E_SUB || expv[9] !== E_ADD || obs[4] !== E_SUB || obs[9] !== E_ADD || obs[21] !== E_DN) begin
            errors++; $display("FAIL known_sched: c4 %h c9 %h c21 %h, want 88 90 81", obs[4], obs[9], obs[21]);
        end
        for (int k = 1; k <= explen + 1; k++) begin
            checks++;
            if (obs[k] !== expv[k]) begin
                errors++; $display("FAIL known_c%0d: got %h, want %h", k, obs[k], expv[k]);
            end
        end
        checks++;
        if (prod[21] !== 16'hFFF1) begin
            errors++; $display("FAIL known_product: got %h, want fff1", prod[21]);
        end
    endtask

    task automatic test_random;
        logic [7:0] a, b;
        for (int t = 0; t < 12; t++) begin
            a = 8'($urandom); b = 8'($urandom);
            mcand = a; mplier = b;
            build_expect(b, 0, 2'b00);
            capture(explen + 1, 0, 0, 0, 0);
            for (int k = 1; k <= explen + 1; k++) begin
                checks++;
                if (obs[k] !== expv[k]) begin
                    errors++; $display("FAIL rand%0d_c%0d: got %h, want %h", t, k, obs[k], expv[k]);
                end
            end
            checks++;
            if (prod[explen] !== ref_prod(a, b)) begin
                errors++; $display("FAIL rand%0d_product: %h*%h got %h, want %h", t, a, b, prod[explen], ref_prod(a, b));
            end
        end
    endtask

    task automatic test_repulse;
        int nd;
        mcand = 8'hFB; mplier = 8'h03;
        build_expect(8'h03, 0, 2'b00);
        capture(explen + 4, 5, 19, 0, 0);
        nd = 0;
        for (int k = 1; k <= explen + 4; k++) begin
            nd += int'(obs[k][0]);
            if (k <= explen + 1) begin
                checks++;
                if (obs[k] !== expv[k]) begin
                    errors++; $display("FAIL repulse_c%0d: got %h, want %h", k, obs[k], expv[k]);
                end
            end
        end
        checks++;
        if (nd != 1 || obs[explen + 3] !== 8'h00) begin
            errors++; $display("FAIL repulse_done_count: got %0d, want 1", nd);
        end
    endtask

    task automatic test_reset_mid;
        int s, nsh, nd;
        logic [7:0] a, b;
        mcand = 8'h37; mplier = 8'($urandom);
        build_expect(mplier, 0, 2'b00);
        s = 0; nsh = 0;
        for (int k = 1; k <= explen; k++)
            if (expv[k] == E_SH) begin
                nsh++;
                if (nsh == 4) s = k;
            end
        start = 1; @(posedge clk); #1; start = 0;
        for (int k = 1; k < s; k++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (ov !== E_SH) begin
            errors++; $display("FAIL rstmid_pre: got %h, want %h", ov, E_SH);
        end
        reset = 1; #1;
        checks++;
        if (ov !== 8'h00 || iter !== 4'd0) begin
            errors++; $display("FAIL rstmid_async: got %h iter %0d, want 00 iter 0", ov, iter);
        end
        @(posedge clk); #1; @(posedge clk); #1;
        reset = 0;
        nd = 0;
        for (int k = 0; k < 30; k++) begin
            nd += int'(done) + int'(busy);
            @(posedge clk); #1;
        end
        checks++;
        if (nd != 0) begin
            errors++; $display("FAIL rstmid_nodone: got %0d active cycles, want 0", nd);
        end
        a = 8'($urandom); b = 8'($urandom);
        mcand = a; mplier = b;
        build_expect(b, 0, 2'b00);
        capture(explen + 1, 0, 0, 0, 0);
        for (int k = 1; k <= explen + 1; k++) begin
            checks++;
            if (obs[k] !== expv[k]) begin
                errors++; $display("FAIL rstmid_after_c%0d: got %h, want %h", k, obs[k], expv[k]);
            end
        end
        checks++;
        if (prod[explen] !== ref_prod(a, b)) begin
            errors++; $display("FAIL rstmid_product: got %h, want %h", prod[explen], ref_prod(a, b));
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] a1, b1, a2, b2;
        a1 = 8'($urandom); b1 = 8'($urandom); a2 = 8'($urandom); b2 = 8'($urandom);
        mcand = a1; mplier = b1;
        build_expect(b1, 0, 2'b00);
        capture(explen + 1, 0, 0, 1, 0);
        for (int k = 1; k <= explen + 1; k++) begin
            checks++;
            if (obs[k] !== expv[k]) begin
                errors++; $display("FAIL b2b_first_c%0d: got %h, want %h", k, obs[k], expv[k]);
            end
        end
        checks++;
        if (prod[explen] !== ref_prod(a1, b1)) begin
            errors++; $display("FAIL b2b_first_product: got %h, want %h", prod[explen], ref_prod(a1, b1));
        end
        mcand = a2; mplier = b2;
        build_expect(b2, 0, 2'b00);
        capture(explen + 1, 0, 0, 0, 1);
        for (int k = 1; k <= explen + 1; k++) begin
            checks++;
            if (obs[k] !== expv[k]) begin
                errors++; $display("FAIL b2b_second_c%0d: got %h, want %h", k, obs[k], expv[k]);
            end
        end
        checks++;
        if (prod[explen] !== ref_prod(a2, b2)) begin
            errors++; $display("FAIL b2b_second_product: got %h, want %h", prod[explen], ref_prod(a2, b2));
        end
    endtask

`ifdef BOOTH_CTRL_ABORT_EN
    task automatic test_abort;
        int s, nd;
        mcand = 8'hFB; mplier = 8'h03;
        build_expect(8'h03, 0, 2'b00);
        s = 0;
        for (int k = explen; k >= 1; k--)
            if (expv[k] == E_ADD) s = k;
        start = 1; @(posedge clk); #1; start = 0;
        for (int k = 1; k < s; k++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (ov !== E_ADD) begin
            errors++; $display("FAIL abort_pre: got %h, want %h", ov, E_ADD);
        end
        abort = 1; @(posedge clk); #1; abort = 0;
        checks++;
        if (ov !== 8'h00) begin
            errors++; $display("FAIL abort_idle: got %h, want 00", ov);
        end
        nd = 0;
        for (int k = 0; k < 25; k++) begin
            nd += int'(done);
            @(posedge clk); #1;
        end
        checks++;
        if (nd != 0) begin
            errors++; $display("FAIL abort_nodone: got %0d, want 0", nd);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_shift_only;
        test_add_all;
        test_known;
        test_random;
        test_repulse;
        test_reset_mid;
        test_back_to_back;
`ifdef BOOTH_CTRL_ABORT_EN
        test_abort;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
